freq_gen_nco: RTL and testbench
===============================

FREQ_GEN_NCO -- requirements
Module: freq_gen_nco

Interface
REQ-001 SHALL have parameter CLK_STAND_FREQ, default 28'd100_000_000; sys_clk frequency in Hz, divisor for tuning-word calculation.
REQ-002 SHALL have parameter ACC_W, default 32; phase-accumulator width.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port freq_set  input  34  requested output frequency in Hz, same width as the meter's freq result.
REQ-006 SHALL have port set_valid  input  1  freq_set is valid this cycle.
REQ-007 SHALL have port set_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL have port tune_word  output  ACC_W  active tuning word.
REQ-009 SHALL have port clk_out  output  1  registered square wave, the accumulator MSB.
REQ-010 SHALL have port range_err  output  1  sticky flag: last request was out of range.

Function
REQ-011 SHALL accept a request on the cycle where set_valid and set_ready are both high; set_valid while set_ready is low SHALL be ignored and not queued.
REQ-012 SHALL use FSM states IDLE, CHECK, DIV and APPLY: IDLE to CHECK on accept; CHECK to DIV if in range, else back to IDLE; DIV to APPLY when the divider reports done; APPLY to IDLE after 1 cycle.
REQ-013 SHALL drive set_ready high only in IDLE.
REQ-014 SHALL treat a request as in range when freq_set <= CLK_STAND_FREQ/2 (50_000_000); otherwise it SHALL set range_err, keep tune_word unchanged and skip division.
REQ-015 SHALL compute tune_word = floor(freq_set * 2^ACC_W / CLK_STAND_FREQ) with a 66-bit dividend and a 28-bit divisor; the quotient SHALL be truncated to ACC_W bits, which is lossless in range.
REQ-016 SHALL use a restoring divider producing 1 quotient bit per cycle, so DIV lasts exactly 66 cycles.
REQ-017 SHALL make the new tune_word visible on the cycle after APPLY, i.e. 69 cycles after the accept edge.
REQ-018 SHALL clear range_err on the next in-range accept.
REQ-019 SHALL add tune_word to the phase accumulator every cycle modulo 2^ACC_W, with wrap-around silent.
REQ-020 SHALL register clk_out from acc[ACC_W-1], giving 1 cycle of latency.
REQ-021 SHALL, when freq_set = 0, run the full division and apply tune_word = 0, freezing clk_out at its current level.
REQ-022 SHALL keep the old tune_word driving the accumulator throughout CHECK and DIV, so there is no output glitch during calculation.

Reset
REQ-023 SHALL, while sys_rst is asserted (including mid-division), asynchronously clear the FSM to IDLE, clear the accumulator, tune_word, clk_out and range_err to 0, and clear divider state.
REQ-024 SHALL drive set_ready to 1 on the first cycle after sys_rst deasserts.

Configuration
REQ-025 SHALL use macro FREQ_GEN_PHASE_RST_EN: when defined, the accumulator SHALL be cleared to 0 in APPLY so every new frequency starts at phase 0 with clk_out low; when undefined, the accumulator SHALL continue from its current phase (phase-continuous switching).

Structure
REQ-026 SHALL place CLK_STAND_FREQ, the ACC_W default, the 66-bit dividend width, the divide cycle count (66) and the FSM state encoding in shared package freq_meter_pkg, shared with the meter.
REQ-027 SHALL implement the division in sub-module freq_gen_div, a sequential restoring divider with start/done handshake, 1 bit per cycle.

Verification
REQ-028 SHALL cover: freq_set=1_000_000 accepted -> tune_word=42_949_672 exactly 69 cycles later; clk_out period ~100 cycles.
REQ-029 SHALL cover: freq_set=25_000_000 -> tune_word=1_073_741_824; clk_out toggles every 2 cycles (period 4).
REQ-030 SHALL cover: freq_set=50_000_001 after a 1 MHz setting -> range_err=1, tune_word stays 42_949_672, set_ready back high 2 cycles after accept.
REQ-031 SHALL cover: freq_set=0 -> tune_word=0, clk_out constant for 1000 cycles; a following in-range request clears range_err.
REQ-032 SHALL cover: set_valid pulsed during DIV with 10_000_000 -> ignored, first request result applied; sys_rst asserted at DIV cycle 30 -> all outputs 0 immediately, set_ready=1 after release.
REQ-033 SHALL cover: with FREQ_GEN_PHASE_RST_EN defined, clk_out=0 on the 2 cycles after APPLY; without it, no phase discontinuity.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency meter / NCO generator pair.
// Holds the reference clock rate, accumulator width default, divider sizing
// and the generator FSM encoding.
package freq_meter_pkg;

    // Reference clock in Hz; also the divisor of the tuning-word calculation.
    localparam logic [27:0] CLK_STAND_FREQ = 28'd100_000_000;

    // Phase accumulator width default.
    localparam int ACC_W_DEF = 32;

    // Frequency word width, shared with the meter result.
    localparam int FREQ_W = 34;

    // Divider sizing: freq (34 bits) shifted by ACC_W (32) gives a 66-bit dividend.
    localparam int DIVISOR_W  = 28;
    localparam int DIVIDEND_W = 66;
    localparam int DIV_CYCLES = 66;
    localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);

    // Generator control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DIV   = 2'd2,
        APPLY = 2'd3
    } gen_state_t;

    // A request is legal up to the Nyquist limit of the reference clock.
    function automatic logic freq_in_range(input logic [FREQ_W-1:0]    freq,
                                           input logic [DIVISOR_W-1:0] clk_hz);
        return freq <= FREQ_W'(clk_hz >> 1);
    endfunction

endpackage

// File: rtl/freq_gen_div.sv
// Sequential restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; done is high during the cycle whose
// closing edge retires the last quotient bit, so the quotient is valid on
// the following cycle.
module freq_gen_div
    import freq_meter_pkg::*;
#(
    parameter int Q_W = ACC_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [Q_W-1:0]        quotient
);

    logic                  busy;
    logic [DIV_CNT_W-1:0]  cnt;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dvs;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [DIVIDEND_W-1:0] q;

    logic [DIVISOR_W:0]    rem_sh;
    logic [DIVISOR_W:0]    diff;
    logic                  take;
    logic [DIVISOR_W-1:0]  rem_nx;

    // Trial subtraction; the borrow bit decides whether the quotient bit is 1.
    always_comb begin
        rem_sh = {rem, q[DIVIDEND_W-1]};
        diff   = rem_sh - {1'b0, dvs};
        take   = ~diff[DIVISOR_W];
        rem_nx = take ? diff[DIVISOR_W-1:0] : rem_sh[DIVISOR_W-1:0];
    end

    assign done     = busy && (cnt == DIV_CNT_W'(DIV_CYCLES - 1));
    assign quotient = q[Q_W-1:0];

    // Operand load on start, then one restoring step per cycle while busy.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dvs  <= '0;
            q    <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            rem  <= '0;
            dvs  <= divisor;
            q    <= dividend;
        end else if (busy) begin
            rem  <= rem_nx;
            q    <= {q[DIVIDEND_W-2:0], take};
            cnt  <= cnt + DIV_CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/freq_gen_nco.sv
// Numerically controlled oscillator with a frequency-in-Hz request port.
// A request is range-checked, converted to a tuning word by a 66-cycle
// restoring division, and applied in one step; the old tuning word keeps
// driving the accumulator until then.
// Optional build macro FREQ_GEN_PHASE_RST_EN: restart the accumulator at
// phase 0 (clk_out low) whenever a new tuning word is applied; without it
// frequency changes are phase-continuous.
module freq_gen_nco #(
    parameter logic [27:0] CLK_STAND_FREQ = freq_meter_pkg::CLK_STAND_FREQ,
    parameter int          ACC_W          = freq_meter_pkg::ACC_W_DEF
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic [freq_meter_pkg::FREQ_W-1:0] freq_set,
    input  logic                              set_valid,
    output logic                              set_ready,
    output logic [ACC_W-1:0]                  tune_word,
    output logic                              clk_out,
    output logic                              range_err
);

    import freq_meter_pkg::*;

    gen_state_t            state_q;
    gen_state_t            state_d;
    logic                  accept;
    logic                  div_start;
    logic                  div_done;
    logic                  req_in_range;
    logic [FREQ_W-1:0]     freq_req;
    logic [DIVIDEND_W-1:0] dividend;
    logic [ACC_W-1:0]      div_q;
    logic [ACC_W-1:0]      acc;

    assign set_ready    = (state_q == IDLE);
    assign accept       = set_valid && set_ready;
    assign req_in_range = freq_in_range(freq_req, CLK_STAND_FREQ);
    assign dividend     = DIVIDEND_W'(freq_req) << ACC_W;

    // Capture the requested frequency on accept; held for CHECK and DIV.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            freq_req <= freq_set;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the divider is kicked off when CHECK passes.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (req_in_range) begin
                    state_d   = DIV;
                    div_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    freq_gen_div #(
        .Q_W      (ACC_W)
    ) u_div (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (CLK_STAND_FREQ),
        .done     (div_done),
        .quotient (div_q)
    );

    // Sticky range error: cleared by an in-range accept, set when CHECK rejects.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            range_err <= 1'b0;
        end else if (accept && freq_in_range(freq_set, CLK_STAND_FREQ)) begin
            range_err <= 1'b0;
        end else if (state_q == CHECK && !req_in_range) begin
            range_err <= 1'b1;
        end
    end

    // Tuning word only changes when leaving APPLY.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tune_word <= '0;
        end else if (state_q == APPLY) begin
            tune_word <= div_q;
        end
    end

    // Phase accumulator and registered MSB output.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc     <= '0;
            clk_out <= 1'b0;
        end else begin
`ifdef FREQ_GEN_PHASE_RST_EN
            if (state_q == APPLY) begin
                acc     <= '0;
                clk_out <= 1'b0;
            end else begin
                acc     <= acc + tune_word;
                clk_out <= acc[ACC_W-1];
            end
`else
            acc     <= acc + tune_word;
            clk_out <= acc[ACC_W-1];
`endif
        end
    end

endmodule

// File: tb/tb_freq_gen_nco.sv
// Self-checking bench for freq_gen_nco: tuning-word results through a
// scoreboard queue, clk_out tracked against an accumulator model.
module tb_freq_gen_nco;

    logic        sys_clk;
    logic        sys_rst;
    logic [33:0] freq_set;
    logic        set_valid;
    logic        set_ready;
    logic [31:0] tune_word;
    logic        clk_out;
    logic        range_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_tw_q[$];
    logic        exp_err_q[$];

    // Accumulator model, loaded by the test timeline on the APPLY cycle.
    logic [31:0] m_acc;
    logic [31:0] m_tw;
    logic        m_clk;
    logic        m_load = 1'b0;
    logic [31:0] m_next_tw = '0;

    freq_gen_nco dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .freq_set  (freq_set),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .tune_word (tune_word),
        .clk_out   (clk_out),
        .range_err (range_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_acc <= '0;
            m_tw  <= '0;
            m_clk <= 1'b0;
        end else begin
            m_clk <= m_acc[31];
            m_acc <= m_acc + m_tw;
            if (m_load) begin
                m_tw <= m_next_tw;
`ifdef FREQ_GEN_PHASE_RST_EN
                m_acc <= '0;
                m_clk <= 1'b0;
`endif
            end
        end
    end

    function automatic logic [31:0] ref_tw(input logic [33:0] f);
        logic [65:0] num;
        num = {f, 32'd0};
        return 32'(num / 66'd100_000_000);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Wait (bounded) for set_ready, then present one request for one edge.
    task automatic accept_req(input logic [33:0] f);
        for (int i = 0; i < 200 && set_ready !== 1'b1; i++) tick();
        total++;
        if (set_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout: set_ready=%b required 1", set_ready);
        end
        freq_set  = f;
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
    endtask

    // From cycle 1 after accept, step to the APPLY cycle, sample, load the model, step once more.
    task automatic run_to_apply(input logic [31:0] tw, output logic [31:0] tw_before,
                                output logic rdy_before);
        repeat (67) tick();
        tw_before  = tune_word;
        rdy_before = set_ready;
        m_next_tw  = tw;
        m_load     = 1'b1;
        tick();
        m_load     = 1'b0;
    endtask

    // Watch clk_out for n cycles against the model and collect timing.
    task automatic observe(input int n, output int mism, output int changes,
                           output int min_gap, output int max_gap);
        logic prev;
        int   last_rise;
        mism = 0; changes = 0; min_gap = 1000000; max_gap = 0; last_rise = -1;
        prev = clk_out;
        for (int i = 0; i < n; i++) begin
            tick();
            if (clk_out !== m_clk) mism++;
            if (clk_out !== prev) changes++;
            if (prev === 1'b0 && clk_out === 1'b1) begin
                if (last_rise >= 0) begin
                    if (i - last_rise < min_gap) min_gap = i - last_rise;
                    if (i - last_rise > max_gap) max_gap = i - last_rise;
                end
                last_rise = i;
            end
            prev = clk_out;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) tick();
        total++; if (tune_word !== 32'd0) begin bad++; $display("FAIL rst_tune_word: got %0d want 0", tune_word); end
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rst_clk_out: got %b want 0", clk_out); end
        total++; if (range_err !== 1'b0) begin bad++; $display("FAIL rst_range_err: got %b want 0", range_err); end
        sys_rst = 1'b0;
        tick();
        total++; if (set_ready !== 1'b1) begin bad++; $display("FAIL rst_set_ready: got %b want 1", set_ready); end
    endtask

    task automatic test_tune_1m();
        logic [31:0] tw_b, exp_tw;
        logic        rdy_b;
        int mism, ch, gmin, gmax;
        exp_tw_q.push_back(32'd42_949_672);
        accept_req(34'd1_000_000);
        run_to_apply(32'd42_949_672, tw_b, rdy_b);
        total++; if (tw_b !== 32'd0) begin bad++; $display("FAIL tw_1m_cycle68: got %0d want 0", tw_b); end
        total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL ready_in_apply: got %b want 0", rdy_b); end
        exp_tw = exp_tw_q.pop_front();
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL tw_1m_cycle69: got %0d want %0d", tune_word, exp_tw); end
        total++; if (set_ready !== 1'b1) begin bad++; $display("FAIL ready_after_1m: got %b want 1", set_ready); end
        observe(450, mism, ch, gmin, gmax);
        total++; if (mism !== 0) begin bad++; $display("FAIL clk_track_1m: mismatches %0d want 0", mism); end
        total++; if (gmin < 100 || gmax > 101 || gmax < 100) begin bad++; $display("FAIL period_1m: gaps %0d..%0d want 100..101", gmin, gmax); end
    endtask

    task automatic test_tune_25m();
        logic [31:0] tw_b, exp_tw;
        logic        rdy_b;
        int mism, ch, gmin, gmax;
        exp_tw_q.push_back(32'd1_073_741_824);
        accept_req(34'd25_000_000);
        run_to_apply(32'd1_073_741_824, tw_b, rdy_b);
        total++; if (tw_b !== 32'd42_949_672) begin bad++; $display("FAIL tw_hold_during_div: got %0d want 42949672", tw_b); end
        exp_tw = exp_tw_q.pop_front();
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL tw_25m: got %0d want %0d", tune_word, exp_tw); end
`ifdef FREQ_GEN_PHASE_RST_EN
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL phase_rst_c1: got %b want 0", clk_out); end
        tick();
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL phase_rst_c2: got %b want 0", clk_out); end
`else
        tick();
`endif
        observe(4, mism, ch, gmin, gmax);
        total++; if (mism !== 0) begin bad++; $display("FAIL clk_track_switch: mismatches %0d want 0", mism); end
        observe(40, mism, ch, gmin, gmax);
        total++; if (mism !== 0) begin bad++; $display("FAIL clk_track_25m: mismatches %0d want 0", mism); end
        total++; if (ch !== 20 || gmin !== 4 || gmax !== 4) begin bad++; $display("FAIL period_25m: changes=%0d gaps %0d..%0d want 20 and 4..4", ch, gmin, gmax); end
    endtask

    task automatic test_range_err();
        logic [31:0] tw_b, exp_tw;
        logic        rdy_b, exp_err;
        int mism, ch, gmin, gmax;
        exp_tw_q.push_back(ref_tw(34'd1_000_000));
        accept_req(34'd1_000_000);
        run_to_apply(ref_tw(34'd1_000_000), tw_b, rdy_b);
        exp_tw = exp_tw_q.pop_front();
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL tw_1m_again: got %0d want %0d", tune_word, exp_tw); end
        exp_tw_q.push_back(32'd42_949_672);
        exp_err_q.push_back(1'b1);
        accept_req(34'd50_000_001);
        total++; if (set_ready !== 1'b0) begin bad++; $display("FAIL oor_ready_c1: got %b want 0", set_ready); end
        tick();
        exp_tw  = exp_tw_q.pop_front();
        exp_err = exp_err_q.pop_front();
        total++; if (set_ready !== 1'b1) begin bad++; $display("FAIL oor_ready_c2: got %b want 1", set_ready); end
        total++; if (range_err !== exp_err) begin bad++; $display("FAIL oor_range_err: got %b want %b", range_err, exp_err); end
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL oor_tw_kept: got %0d want %0d", tune_word, exp_tw); end
        observe(200, mism, ch, gmin, gmax);
        total++; if (mism !== 0) begin bad++; $display("FAIL clk_track_oor: mismatches %0d want 0", mism); end
    endtask

    task automatic test_zero();
        logic [31:0] tw_b, exp_tw;
        logic        rdy_b, lvl;
        int mism, ch, gmin, gmax;
        exp_tw_q.push_back(32'd0);
        accept_req(34'd0);
        total++; if (range_err !== 1'b0) begin bad++; $display("FAIL zero_clears_err: got %b want 0", range_err); end
        run_to_apply(32'd0, tw_b, rdy_b);
        exp_tw = exp_tw_q.pop_front();
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL tw_zero: got %0d want %0d", tune_word, exp_tw); end
        tick();
        lvl = m_clk;
        observe(1000, mism, ch, gmin, gmax);
        total++; if (ch !== 0 || clk_out !== lvl) begin bad++; $display("FAIL zero_frozen: changes=%0d level=%b want 0 changes level %b", ch, clk_out, lvl); end
        accept_req(34'd60_000_000);
        tick();
        total++; if (range_err !== 1'b1) begin bad++; $display("FAIL oor_60m: got %b want 1", range_err); end
        exp_tw_q.push_back(ref_tw(34'd10_000_000));
        accept_req(34'd10_000_000);
        total++; if (range_err !== 1'b0) begin bad++; $display("FAIL inrange_clears_err: got %b want 0", range_err); end
        run_to_apply(ref_tw(34'd10_000_000), tw_b, rdy_b);
        exp_tw = exp_tw_q.pop_front();
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL tw_10m: got %0d want %0d", tune_word, exp_tw); end
    endtask

    task automatic test_ignore_during_div();
        logic [31:0] exp_tw;
        logic        rdy_mid;
        int mism, ch, gmin, gmax;
        exp_tw_q.push_back(ref_tw(34'd5_000_000));
        accept_req(34'd5_000_000);
        rdy_mid = 1'b1;
        for (int k = 1; k <= 67; k++) begin
            set_valid = (k >= 10 && k <= 12);
            freq_set  = set_valid ? 34'd10_000_000 : 34'd5_000_000;
            if (k == 11) rdy_mid = set_ready;
            tick();
        end
        set_valid = 1'b0;
        m_next_tw = ref_tw(34'd5_000_000);
        m_load    = 1'b1;
        tick();
        m_load    = 1'b0;
        total++; if (rdy_mid !== 1'b0) begin bad++; $display("FAIL ready_in_div: got %b want 0", rdy_mid); end
        exp_tw = exp_tw_q.pop_front();
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL tw_first_req: got %0d want %0d", tune_word, exp_tw); end
        observe(100, mism, ch, gmin, gmax);
        total++; if (tune_word !== exp_tw || set_ready !== 1'b1) begin bad++; $display("FAIL not_queued: tw=%0d ready=%b want %0d and 1", tune_word, set_ready, exp_tw); end
        total++; if (mism !== 0) begin bad++; $display("FAIL clk_track_5m: mismatches %0d want 0", mism); end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] tw_b, exp_tw;
        logic        rdy_b;
        int mism, ch, gmin, gmax;
        accept_req(34'd20_000_000);
        repeat (30) tick();
        #2 sys_rst = 1'b1;
        #1;
        total++; if (tune_word !== 32'd0 || clk_out !== 1'b0 || range_err !== 1'b0) begin
            bad++; $display("FAIL rst_mid_div: tw=%0d clk=%b err=%b want all 0", tune_word, clk_out, range_err);
        end
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        total++; if (set_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst: got %b want 1", set_ready); end
        total++; if (tune_word !== 32'd0) begin bad++; $display("FAIL tw_after_rst: got %0d want 0", tune_word); end
        exp_tw_q.push_back(32'd1_073_741_824);
        accept_req(34'd25_000_000);
        run_to_apply(32'd1_073_741_824, tw_b, rdy_b);
        exp_tw = exp_tw_q.pop_front();
        total++; if (tune_word !== exp_tw) begin bad++; $display("FAIL tw_post_rst: got %0d want %0d", tune_word, exp_tw); end
        observe(40, mism, ch, gmin, gmax);
        total++; if (mism !== 0) begin bad++; $display("FAIL clk_track_post_rst: mismatches %0d want 0", mism); end
    endtask

    initial begin
        sys_rst   = 1'b1;
        set_valid = 1'b0;
        freq_set  = '0;
        test_reset();
        test_tune_1m();
        test_tune_25m();
        test_range_err();
        test_zero();
        test_ignore_during_div();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
